mem_port_arbiter: RTL and testbench

- Shares the single main-memory bus between two requesters: port 0 is the data cache controller (refill/write-back traffic), port 1 is the instruction fetch path.
- Sits between those requesters and the external memory.
- Forwards one address-phase request per accepted handshake, using round-robin priority.
- Records the issuing port of every accepted transaction in an ID FIFO, so in-order mem_rvalid/mem_rdata responses route back to the correct requester.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter onto a single memory bus, with an in-order ID FIFO
// that steers each memory response back to the port that issued the request.
module mem_port_arbiter #(
  parameter int unsigned addr_width      = 32,
  parameter int unsigned data_width      = 32,
  parameter int unsigned max_outstanding = 2
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [1:0]              req_i,
  input  logic [2*addr_width-1:0] addr_i,
  input  logic [1:0]              we_i,
  input  logic [7:0]              be_i,
  input  logic [2*data_width-1:0] wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [data_width-1:0]   rdata_o,
  output logic                    mem_req,
  output logic [addr_width-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [data_width-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [data_width-1:0]   mem_rdata,
  output logic                    proto_err_o
);

  localparam int unsigned ptr_w = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
  localparam int unsigned cnt_w = $clog2(max_outstanding) + 1;
  localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(max_outstanding);
  localparam logic [ptr_w-1:0] ptr_last = ptr_w'(max_outstanding - 1);

  typedef enum logic {st_free, st_locked} state_t;

  state_t           state, state_n;
  logic             lock_id, lock_id_n;
  logic             last_id, last_id_n;
  logic [cnt_w-1:0] count, count_n;
  logic [ptr_w-1:0] wr_ptr, wr_ptr_n;
  logic [ptr_w-1:0] rd_ptr, rd_ptr_n;
  logic             proto_err_n;
  logic             id_mem [max_outstanding];
  logic             sel, accept, pop, full, head;

  // Port selection: a presented but ungranted request pins the selection.
  always_comb begin
    sel = 1'b0;
    if (!rst) begin
      sel = 1'b0;
    end else if (state == st_locked) begin
      sel = lock_id;
    end else begin
      case (req_i)
        2'b10:   sel = 1'b1;
        2'b11:   sel = ~last_id;
        default: sel = 1'b0;
      endcase
    end
  end

  assign full     = (count == cnt_max);
  assign mem_req  = rst && req_i[sel] && !full;
  assign accept   = mem_req && mem_gnt;
  assign pop      = mem_rvalid && (count != '0);
  assign head     = id_mem[rd_ptr];
  assign gnt_o    = {accept && sel, accept && !sel};
  assign rvalid_o = {pop && head, pop && !head};
  assign rdata_o  = mem_rdata;

  assign mem_addr  = sel ? addr_i[addr_width +: addr_width] : addr_i[0 +: addr_width];
  assign mem_wdata = sel ? wdata_i[data_width +: data_width] : wdata_i[0 +: data_width];
  assign mem_be    = sel ? be_i[7:4] : be_i[3:0];
  assign mem_we    = we_i[sel];

  // Next-state for lock FSM, FIFO bookkeeping and the sticky error flag.
  always_comb begin
    state_n     = state;
    lock_id_n   = lock_id;
    last_id_n   = last_id;
    count_n     = count;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    proto_err_n = proto_err_o;

    case (state)
      st_free: begin
        if (mem_req && !mem_gnt) begin
          state_n   = st_locked;
          lock_id_n = sel;
        end
      end
      st_locked: begin
        if (accept || !req_i[lock_id]) state_n = st_free;
      end
      default: state_n = st_free;
    endcase

    if (accept) begin
      last_id_n = sel;
      wr_ptr_n  = (wr_ptr == ptr_last) ? '0 : wr_ptr + ptr_w'(1);
    end
    if (pop) rd_ptr_n = (rd_ptr == ptr_last) ? '0 : rd_ptr + ptr_w'(1);

    case ({accept, pop})
      2'b10:   count_n = count + cnt_w'(1);
      2'b01:   count_n = count - cnt_w'(1);
      default: count_n = count;
    endcase

    if (mem_rvalid && (count == '0)) proto_err_n = 1'b1;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= st_free;
      lock_id     <= 1'b0;
      last_id     <= 1'b1;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      lock_id     <= lock_id_n;
      last_id     <= last_id_n;
      count       <= count_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      proto_err_o <= proto_err_n;
    end
  end

  // ID FIFO storage: one entry per accepted, unanswered transaction.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(max_outstanding); i++) id_mem[i] <= 1'b0;
    end else if (accept) begin
      id_mem[wr_ptr] <= sel;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand-written lock and reset sequences.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic [1:0]  req_i = 2'b00;
  logic [63:0] addr_i  = {32'h0000_2000, 32'h0000_1000};
  logic [1:0]  we_i    = 2'b10;
  logic [7:0]  be_i    = 8'hC3;
  logic [63:0] wdata_i = {32'h2222_2222, 32'h1111_1111};
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt    = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  logic        proto_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.addr_width(32), .data_width(32), .max_outstanding(2)) dut (
    .clock(clock), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .proto_err_o(proto_err_o)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        exp_req;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic        exp_sel;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] rq, logic g, logic v, logic [31:0] d,
                              logic er, logic [1:0] eg, logic [1:0] ev, logic es, logic ee);
    vec_t x;
    x.rst = r; x.req = rq; x.gnt = g; x.rv = v; x.rdata = d;
    x.exp_req = er; x.exp_gnt = eg; x.exp_rv = ev; x.exp_sel = es; x.exp_err = ee;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the falling edge, check combinational and registered outputs mid-phase.
  task automatic step(input vec_t v, input string tag);
    @(negedge clock);
    rst = v.rst; req_i = v.req; mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rdata;
    #2;
    check({tag, ".mem_req"},   64'(mem_req),     64'(v.exp_req));
    check({tag, ".gnt_o"},     64'(gnt_o),       64'(v.exp_gnt));
    check({tag, ".rvalid_o"},  64'(rvalid_o),    64'(v.exp_rv));
    check({tag, ".mem_addr"},  64'(mem_addr),    v.exp_sel ? 64'h2000 : 64'h1000);
    check({tag, ".mem_we"},    64'(mem_we),      64'(v.exp_sel));
    check({tag, ".mem_be"},    64'(mem_be),      v.exp_sel ? 64'hC : 64'h3);
    check({tag, ".mem_wdata"}, 64'(mem_wdata),   v.exp_sel ? 64'h2222_2222 : 64'h1111_1111);
    check({tag, ".proto_err"}, 64'(proto_err_o), 64'(v.exp_err));
    if (v.exp_rv != 2'b00) check({tag, ".rdata_o"}, 64'(rdata_o), 64'(v.rdata));
  endtask

  initial begin
    // reset, then single port-0 read
    vecs.push_back(mk(0, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 1, 0, 0,            1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 1, 32'hDEADBEEF, 0, 2'b00, 2'b01, 0, 0));
    // reset with both requesting, then alternating grants with routed responses
    vecs.push_back(mk(0, 2'b11, 1, 0, 0,            0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0,            1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b11, 1, 1, 32'hA1,       1, 2'b10, 2'b01, 1, 0));
    vecs.push_back(mk(1, 2'b11, 1, 1, 32'hA2,       1, 2'b01, 2'b10, 0, 0));
    vecs.push_back(mk(1, 2'b11, 1, 1, 32'hA3,       1, 2'b10, 2'b01, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0, 1, 32'hA4,       0, 2'b00, 2'b10, 0, 0));
    // port 1 held by lock while mem_gnt low, port 0 follows
    vecs.push_back(mk(1, 2'b10, 0, 0, 0,            1, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 2'b11, 0, 0, 0,            1, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 2'b11, 0, 0, 0,            1, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0,            1, 2'b10, 2'b00, 1, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0,            1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 1, 32'hB1,       0, 2'b00, 2'b10, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 1, 32'hB2,       0, 2'b00, 2'b01, 0, 0));
    // stray response with nothing outstanding
    vecs.push_back(mk(1, 2'b00, 0, 1, 32'hE0,       0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0, 1));
    // fill to max_outstanding, stall, pop+push with count held
    vecs.push_back(mk(1, 2'b01, 1, 0, 0,            1, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 2'b01, 1, 0, 0,            1, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 2'b01, 1, 0, 0,            0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk(1, 2'b01, 1, 1, 32'hC1,       0, 2'b00, 2'b01, 0, 1));
    vecs.push_back(mk(1, 2'b01, 1, 1, 32'hC2,       1, 2'b01, 2'b01, 0, 1));
    vecs.push_back(mk(1, 2'b01, 1, 0, 0,            1, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 2'b01, 1, 0, 0,            0, 2'b00, 2'b00, 0, 1));
    // reset with two outstanding; a later response is a protocol error
    vecs.push_back(mk(0, 2'b01, 1, 0, 0,            0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 1, 32'hF0,       0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0, 1));

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // requester drops a locked request: lock released, nothing recorded
    step(mk(1, 2'b10, 0, 0, 0,      1, 2'b00, 2'b00, 1, 1), "drop0");
    step(mk(1, 2'b01, 0, 0, 0,      0, 2'b00, 2'b00, 1, 1), "drop1");
    step(mk(1, 2'b01, 1, 0, 0,      1, 2'b01, 2'b00, 0, 1), "drop2");
    step(mk(1, 2'b00, 0, 1, 32'hD1, 0, 2'b00, 2'b01, 0, 1), "drop3");
    step(mk(1, 2'b00, 0, 1, 32'hD2, 0, 2'b00, 2'b00, 0, 1), "drop4");

    // asynchronous reset takes effect without a clock edge
    step(mk(1, 2'b01, 0, 0, 0,      1, 2'b00, 2'b00, 0, 1), "async0");
    @(posedge clock);
    #1;
    mem_gnt = 1'b1;
    #1;
    check("async.gnt_pre", 64'(gnt_o), 64'h1);
    rst = 1'b0;
    #1;
    check("async.gnt_o",     64'(gnt_o),       64'h0);
    check("async.mem_req",   64'(mem_req),     64'h0);
    check("async.proto_err", 64'(proto_err_o), 64'h0);
    step(mk(1, 2'b00, 0, 0, 0,      0, 2'b00, 2'b00, 0, 0), "async1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
